raw_to_gray: RTL and testbench
==============================

# raw_to_gray

Front-end stage of the camera edge-detection path. Accepts the 12-bit Bayer raw pixel stream and collapses each 2x2 Bayer quad (R, G1, G2, B) into one 12-bit grayscale pixel equal to their average. The result is a half-width, half-height grayscale stream with a per-pixel valid strobe, which feeds the Sobel convolution stage's `pixel_in`/`iDVAL` inputs directly.

## Interface
- `LINE_WIDTH`, 1280: raw pixels per line. Must be even and ≥ 4.
- `DATA_W`, 12: pixel width, in and out.
- `iCLK` in 1: pixel clock; all logic is on the rising edge.
- `iRST` in 1: reset, asynchronous, active-high.
- `iFVAL` in 1: frame valid. Low means the block is between frames.
- `iDVAL` in 1: input pixel valid, qualified by `iFVAL`.
- `iDATA` in `DATA_W`: raw Bayer pixel.
- `oDATA` out `DATA_W`: grayscale pixel.
- `oDVAL` out 1: one-cycle strobe, `oDATA` valid.
- `oLINE_ERR` out 1: sticky flag, frame ended on a partial line or quad.

## Operation
- An input beat is a cycle with `iFVAL & iDVAL` both high. All other cycles are ignored: no state advances and the buffer does not shift.
- `col` counter runs 0..`LINE_WIDTH`-1 and increments once per beat.
  - At `LINE_WIDTH`-1 it wraps to 0 and toggles `row_odd`.
- While `iFVAL` is low, `col` and `row_odd` are held at 0. The first line of every frame is therefore an even row.
- Line buffer: a shift register of depth `LINE_WIDTH`, clock-enabled by beats.
  - Its tap `above` is the pixel from the same column one row earlier.
- Column-delay registers `cur_d` and `above_d` hold `iDATA` and `above` from the previous beat.
- Quad complete: a beat with `row_odd=1` and `col[0]=1`.
  - On that beat, compute `sum = iDATA + cur_d + above + above_d`. `SUM_W` = `DATA_W`+2 = 14 bits.
  - The maximum sum is 16380, so the sum cannot overflow.
  - Register `oDATA <= sum[SUM_W-1:2]` (truncating divide by 4) and pulse `oDVAL=1`.
- `oDATA` holds its last value between strobes.
- Output count per frame is (`LINE_WIDTH`/2) × (rows/2).
- Line buffer contents are never cleared. Stale data is never used, because every odd row is preceded by a fully shifted even row.
- `oLINE_ERR` is set on a falling edge of `iFVAL` (registered `iFVAL` 1→0) when `col`≠0 or `row_odd`=1. It clears only on `iRST`.

## Timing
- Reset values: `oDATA`=0, `oDVAL`=0, `oLINE_ERR`=0, `col`=0, `row_odd`=0, delay registers 0.
  - The buffer is flushed to 0 by reset.
- Latency: `oDVAL` rises in the cycle after the quad-completing beat and lasts exactly 1 cycle.
- Throughput: at most one output per 4 beats, with at least 1 idle cycle between `oDVAL` pulses within a line. No backpressure exists; the downstream stage must accept every strobe.
- Idle gaps in `iDVAL` are allowed anywhere. They do not change output values, only output timing.
- `iFVAL` drops mid-line:
  - Counters return to 0 on the next edge.
  - A pending quad produces no output.
  - `oLINE_ERR` is set.
- A beat coincident with `col` wrap is processed normally: the wrap and toggle happen in the same edge as that beat's shift.
- `iRST` asserted mid-operation clears all registers immediately, asynchronously. An `oDVAL` pulse in flight is dropped.

## Structure
- Package `raw2gray_pkg` holds `DATA_W`, `SUM_W`, and the `pixel_t` typedef (`logic [DATA_W-1:0]`).
- Sub-module `line_shift_buffer`:
  - Parameters: `DEPTH`, `W`.
  - Ports: `iCLK`, `iRST`, `clken`, `din`, `tap`.
  - Implemented as a parameterised shift register or RAM-based delay line.
- Top level contains the counters, delay registers, adder, and the error flag.

## Test plan
- Reset: drive a frame, assert `iRST` mid-line → `oDVAL`, `oDATA` and `oLINE_ERR` go to 0 immediately, and the next full frame gives correct values.
- Uniform frame, `LINE_WIDTH`=4, 4 rows of 100 → exactly 4 outputs of 100, each `oDVAL` one cycle after row1/3 col1/3 beats.
- Bayer pattern R=4095, G1=G2=0, B=1 → every output = 1024 (truncated).
- All pixels 4095 → every output 4095, with no wrap-around.
- Random `iDVAL` gaps (0–3 idle cycles) on a ramp frame → output sequence identical to the gap-free run.
- `iFVAL` drops at col 2 of row 1 → no output for that quad and `oLINE_ERR`=1. The following clean frame still produces correct outputs, with `oLINE_ERR` remaining 1.

Source files
------------

// File: rtl/raw_to_gray_pkg.sv
// Shared types and helpers for the Bayer raw to grayscale front end.
// Pixel width, quad sum width and the quad averaging function.
package raw2gray_pkg;

  localparam int DATA_W = 12;
  localparam int SUM_W  = DATA_W + 2;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [SUM_W-1:0]  sum_t;

  // Two extra bits hold four full-scale pixels, so the sum never wraps.
  function automatic pixel_t quad_avg(
    input pixel_t a,
    input pixel_t b,
    input pixel_t c,
    input pixel_t d
  );
    sum_t s;
    s = sum_t'(a) + sum_t'(b)
      + sum_t'(c) + sum_t'(d);
    return pixel_t'(s >> 2);
  endfunction

endpackage

// File: rtl/raw_to_gray_if.sv
// Pixel stream bundle between the sensor side and the gray stage.
// Raw input beats in, averaged gray strobes and error flag out.
interface raw_to_gray_if
  import raw2gray_pkg::*;
();

  logic   iFVAL;
  logic   iDVAL;
  pixel_t iDATA;
  pixel_t oDATA;
  logic   oDVAL;
  logic   oLINE_ERR;

  modport master (
    output iFVAL,
    output iDVAL,
    output iDATA,
    input  oDATA,
    input  oDVAL,
    input  oLINE_ERR
  );

  modport slave (
    input  iFVAL,
    input  iDVAL,
    input  iDATA,
    output oDATA,
    output oDVAL,
    output oLINE_ERR
  );

endinterface

// File: rtl/raw_to_gray_line_shift_buffer.sv
// One-line delay for the Bayer stream, advanced only on input beats.
// The tap returns the pixel written DEPTH beats earlier.
module line_shift_buffer #(
  parameter int DEPTH = 1280,
  parameter int W     = 12
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         clken,
  input  logic [W-1:0] din,
  output logic [W-1:0] tap
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clken) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign tap = mem_q[DEPTH-1];

endmodule

// File: rtl/raw_to_gray.sv
// Collapses each 2x2 Bayer quad into one averaged gray pixel.
// Emits a one-cycle strobe per quad and a sticky partial-frame flag.
module raw_to_gray
  import raw2gray_pkg::*;
#(
  parameter int LINE_WIDTH = 1280
) (
  input logic          iCLK,
  input logic          iRST,
  raw_to_gray_if.slave bus
);

  localparam int CW = (LINE_WIDTH > 2) ?
    $clog2(LINE_WIDTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(LINE_WIDTH - 1);

  logic          beat;
  logic          quad;
  logic          fall;
  logic [CW-1:0] col_q, col_d;
  logic          row_q, row_d;
  logic          fval_q;
  logic          err_q, err_d;
  logic          dval_q;
  pixel_t        data_q;
  pixel_t        cur_q;
  pixel_t        abv_q;
  pixel_t        above;

  assign beat = bus.iFVAL & bus.iDVAL;
  assign quad = beat & row_q & col_q[0];
  assign fall = fval_q & ~bus.iFVAL;

  line_shift_buffer #(
    .DEPTH (LINE_WIDTH),
    .W     (DATA_W)
  ) u_line (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .clken (beat),
    .din   (bus.iDATA),
    .tap   (above)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    err_d = err_q;
    if (!bus.iFVAL) begin
      col_d = '0;
      row_d = 1'b0;
    end else if (beat) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = ~row_q;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    // col/row are still pre-clear on the edge that sees iFVAL fall
    if (fall && (col_q != '0 || row_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_q  <= '0;
      row_q  <= 1'b0;
      fval_q <= 1'b0;
      err_q  <= 1'b0;
      dval_q <= 1'b0;
      data_q <= '0;
      cur_q  <= '0;
      abv_q  <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      fval_q <= bus.iFVAL;
      err_q  <= err_d;
      dval_q <= quad;
      if (beat) begin
        cur_q <= bus.iDATA;
        abv_q <= above;
      end
      if (quad) begin
        data_q <= quad_avg(bus.iDATA, cur_q,
                           above, abv_q);
      end
    end
  end

  assign bus.oDATA     = data_q;
  assign bus.oDVAL     = dval_q;
  assign bus.oLINE_ERR = err_q;

endmodule

// File: tb/tb_raw_to_gray.sv
// Scoreboard bench for raw_to_gray on a 4-pixel line.
// Frame model pushes expected quads; a monitor pops them.
module tb_raw_to_gray;
  import raw2gray_pkg::*;

  localparam int LW = 4;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  raw_to_gray_if bus ();

  raw_to_gray #(
    .LINE_WIDTH (LW)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  exp_t q[$];
  exp_t e;
  int   pix[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   outcnt = 0;
  int   last = 0;
  int   err_exp = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.oDVAL) begin
        outcnt++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0d at cyc %0d want none",
                   bus.oDATA, cyc);
        end else begin
          e = q.pop_front();
          chk("out_data", int'(bus.oDATA), e.data);
          chk("out_cyc", cyc, e.cyc);
        end
        last = int'(bus.oDATA);
      end else begin
        chk("hold", int'(bus.oDATA), last);
      end
    end
  end

  // Reference: quad completes at odd row, odd column of the flat beat list.
  task automatic model(input int v);
    int k, r, c;
    exp_t x;
    k = pix.size();
    r = k / LW;
    c = k % LW;
    pix.push_back(v);
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      x.data = (pix[k] + pix[k-1] + pix[k-LW]
                + pix[k-LW-1]) / 4;
      x.cyc = cyc + 1;
      q.push_back(x);
    end
  endtask

  task automatic beat(input int v, input int gmax);
    int g;
    g = (gmax > 0) ? $urandom_range(gmax, 0) : 0;
    repeat (g) begin
      @(posedge clk);
      #1 bus.iDVAL = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.iDVAL = 1'b1;
    bus.iDATA = pixel_t'(v);
    model(v);
  endtask

  task automatic frame_start();
    @(posedge clk);
    #1;
    bus.iFVAL = 1'b1;
    bus.iDVAL = 1'b0;
    pix.delete();
  endtask

  task automatic frame_end();
    @(posedge clk);
    #1;
    bus.iDVAL = 1'b0;
    bus.iFVAL = 1'b0;
    if (pix.size() % (2 * LW) != 0) err_exp = 1;
    repeat (3) @(posedge clk);
    #1 chk("line_err", int'(bus.oLINE_ERR), err_exp);
  endtask

  function automatic int pval(input int mode,
                              input int k);
    int r, c;
    r = k / LW;
    c = k % LW;
    case (mode)
      0: return 100;
      1: return (r % 2 == 0 && c % 2 == 0) ? 4095 :
                (r % 2 == 1 && c % 2 == 1) ? 1 : 0;
      2: return 4095;
      3: return (k * 37) % 4096;
      default: return int'($urandom_range(4095, 0));
    endcase
  endfunction

  task automatic run_frame(input int mode,
                           input int rows,
                           input int gmax);
    int c0;
    c0 = outcnt;
    frame_start();
    for (int k = 0; k < rows * LW; k++) begin
      beat(pval(mode, k), gmax);
    end
    frame_end();
    chk("out_count", outcnt - c0,
        (LW / 2) * (rows / 2));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iFVAL = 1'b0;
    bus.iDVAL = 1'b0;
    bus.iDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    pix.delete();
    last = 0;
    err_exp = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.iFVAL = 1'b0;
    bus.iDVAL = 1'b0;
    bus.iDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dval", int'(bus.oDVAL), 0);
    chk("rst_data", int'(bus.oDATA), 0);
    chk("rst_err", int'(bus.oLINE_ERR), 0);
    do_reset();

    run_frame(0, 4, 0);
    run_frame(1, 4, 0);
    run_frame(2, 6, 0);
    run_frame(3, 4, 0);
    run_frame(3, 4, 3);
    run_frame(4, 8, 3);

    frame_start();
    for (int k = 0; k < LW + 2; k++) begin
      beat(pval(4, k), 1);
    end
    frame_end();
    run_frame(4, 4, 2);
    chk("err_sticky", int'(bus.oLINE_ERR), 1);

    frame_start();
    for (int k = 0; k < LW + 2; k++) begin
      beat(pval(3, k) + 500, 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_dval", int'(bus.oDVAL), 0);
    chk("mid_rst_data", int'(bus.oDATA), 0);
    chk("mid_rst_err", int'(bus.oLINE_ERR), 0);
    do_reset();
    run_frame(4, 4, 1);
    run_frame(0, 4, 0);

    repeat (4) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
